// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: byte width, row offsets, byte indexing.
// Used by the ShiftRows pipeline (shift_rows_pipe) and its permutation.
package aes_pkg;

   localparam int AES_BYTE_W = 8;

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   function automatic int row_offset(input int nb, input int r);
      int off;
      off = r;
      if (nb == 8) begin
         unique case (r)
            0: off = 0;
            1: off = 1;
            2: off = 3;
            default: off = 4;
         endcase
      end
      return off;
   endfunction

   function automatic int byte_idx(input int c, input int r);
      return 4 * c + r;
   endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Block stream bus: valid/ready handshake carrying state, tag, direction.
// master drives the block, slave returns ready.
interface shift_rows_pipe_if
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
);

   logic                        valid;
   logic                        ready;
   logic                        inv;
   logic [TAG_W-1:0]            tag;
   logic [0:4*AES_BYTE_W*NB-1]  state;

   modport master (
      output valid, inv, tag, state,
      input  ready
   );

   modport slave (
      input  valid, inv, tag, state,
      output ready
   );

endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Pure wiring plus a per-byte direction mux; bytes are never split.
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic                       inv,
   input  logic [0:4*AES_BYTE_W*NB-1] state_in,
   output logic [0:4*AES_BYTE_W*NB-1] state_out
);

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int OFF = row_offset(NB, r);
         localparam int FWD = (c + OFF) % NB;
         localparam int BWD = (c + NB - OFF) % NB;
         localparam int DST = AES_BYTE_W * byte_idx(c, r);
         localparam int SF  = AES_BYTE_W * byte_idx(FWD, r);
         localparam int SB  = AES_BYTE_W * byte_idx(BWD, r);

         assign state_out[DST +: AES_BYTE_W] =
            inv ? state_in[SB +: AES_BYTE_W]
                : state_in[SF +: AES_BYTE_W];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic ShiftRows / InvShiftRows pipeline with tag and direction sideband.
// Optional SHIFT_ROWS_PIPE_STATS_EN adds blk_count and stall_cycles outputs.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB          = 4,
   parameter int PIPE_STAGES = 1,
   parameter int TAG_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_rows_pipe_if.slave     in_bus,
   shift_rows_pipe_if.master    out_bus
`ifdef SHIFT_ROWS_PIPE_STATS_EN
   ,
   output logic [31:0]          blk_count,
   output logic [31:0]          stall_cycles
`endif
);

   localparam int SW   = 4 * AES_BYTE_W * NB;
   localparam int LAST = PIPE_STAGES - 1;

   if (!nb_legal(NB) || PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_cfg
      $error("shift_rows_pipe: illegal NB or PIPE_STAGES");
   end

   logic [0:SW-1]            perm_state;
   logic [PIPE_STAGES-1:0]   v_q;
   logic [PIPE_STAGES-1:0]   inv_q;
   logic [PIPE_STAGES-1:0]   load;
   logic [0:SW-1]            st_q  [PIPE_STAGES];
   logic [TAG_W-1:0]         tag_q [PIPE_STAGES];

   shift_rows_perm #(
      .NB (NB)
   ) u_perm (
      .inv       (in_bus.inv),
      .state_in  (in_bus.state),
      .state_out (perm_state)
   );

   // A stage may load when it or any stage downstream has a bubble, or output drains
   always_comb begin
      logic acc;
      acc  = out_bus.ready;
      load = '0;
      for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
         acc     = acc || !v_q[i];
         load[i] = acc;
      end
   end

   assign in_bus.ready  = load[0];
   assign out_bus.valid = v_q[LAST];
   assign out_bus.state = st_q[LAST];
   assign out_bus.tag   = tag_q[LAST];
   assign out_bus.inv   = inv_q[LAST];

   // Stage registers; data fields only update when a real block moves in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         inv_q <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            st_q[i]  <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         if (load[0]) begin
            v_q[0] <= in_bus.valid;
         end
         if (load[0] && in_bus.valid) begin
            st_q[0]  <= perm_state;
            tag_q[0] <= in_bus.tag;
            inv_q[0] <= in_bus.inv;
         end
         for (int i = 1; i < PIPE_STAGES; i++) begin
            if (load[i]) begin
               v_q[i] <= v_q[i-1];
            end
            if (load[i] && v_q[i-1]) begin
               st_q[i]  <= st_q[i-1];
               tag_q[i] <= tag_q[i-1];
               inv_q[i] <= inv_q[i-1];
            end
         end
      end
   end

`ifdef SHIFT_ROWS_PIPE_STATS_EN
   // Completed output handshakes (wrapping) and stalled cycles (saturating)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_count    <= '0;
         stall_cycles <= '0;
      end else begin
         if (v_q[LAST] && out_bus.ready) begin
            blk_count <= blk_count + 32'd1;
         end
         if (v_q[LAST] && !out_bus.ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit with per-beat direction select and valid/ready flow control. Supports block widths Nb = 4, 6 and 8 columns. Sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the iterative round datapath. A sideband tag travels with each block.

Parameters:
NB, 4, state columns; legal values are 4, 6, 8 (128/192/256-bit block); any other value is an elaboration error
PIPE_STAGES, 1, register stages after the permutation; legal range 1..3
TAG_W, 4, sideband tag width (round index / context id), passed through unchanged

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block valid
in_ready  out  1  unit can accept a block this cycle
in_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
in_tag  in  TAG_W  sideband, captured with the block
in_state  in  [0:32*NB-1]  state; byte (row r, col c) = bits [8*(4c+r) +: 8], column-major, bit 0 = MSB
out_valid  out  1  output block valid
out_ready  in  1  downstream accepts
out_state  out  [0:32*NB-1]  permuted state, same byte layout
out_tag  out  TAG_W  tag of the output block
out_inv  out  1  direction used for the output block

Behaviour:
- Row offsets C_r: Nb=4 or 6 -> {0,1,2,3}; Nb=8 -> {0,1,3,4}.
- Forward: out[r][c] = in[r][(c + C_r) mod NB]. Inverse: out[r][c] = in[r][(c - C_r) mod NB]. Row 0 is never moved.
- Permutation is pure wiring before stage 0. It is selected per beat by in_inv. No bit inside a byte is reordered.
- Elastic pipeline of PIPE_STAGES registers. Each stage holds v_i, state, tag and inv.
- Stage i loads when !v_i or stage i+1 is loading. The last stage loads when !v_last or out_ready.
- in_ready = !v_0 || (stage 0 advancing). This is combinational from out_ready through the chain; no registered-ready requirement.
- Transfer occurs when valid && ready on the same edge.
- Latency: PIPE_STAGES cycles from input handshake to out_valid. Throughput: 1 block/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, out_state, out_tag and out_inv hold stable. No beat is dropped or duplicated.
- Full pipeline with a simultaneous pop and push: both complete in the same cycle and occupancy is unchanged.
- Mixed-direction streams: each beat uses its own in_inv. Beats never reorder.
- Reset (async assert, sync deassert external): all v_i = 0, all data/tag/inv registers = 0. Outputs: out_valid=0, out_state=0, out_tag=0, out_inv=0, in_ready=1 after reset.
- Reset mid-operation discards in-flight blocks with no partial output.
- in_state is ignored when in_valid=0. Data registers load only on handshake, which saves power.

Optional Feature:
SHIFT_ROWS_PIPE_STATS_EN. When defined, adds output blk_count [31:0] counting completed output handshakes. It wraps 0xFFFF_FFFF -> 0 and resets to 0. It also adds output stall_cycles [31:0] counting cycles with out_valid && !out_ready, saturating at 0xFFFF_FFFF. When undefined, these ports and counters do not exist and the datapath is identical.

Decomposition:
- Shared package aes_pkg holds the following:
  - Nb-to-row-offset function or constant table
  - byte-index helper (4c+r)
  - legal-NB check
  - AES_BYTE_W = 8
- Natural sub-module: shift_rows_perm. It is combinational, with parameters NB and in_inv, and produces the permuted state. It is reused by the key-schedule-free single-cycle round variant.
- The pipeline/handshake logic stays in shift_rows_pipe.

Test Plan:
- NB=4, PIPE_STAGES=1, inv=0, in_state=0x000102030405060708090a0b0c0d0e0f, tag=3 -> one cycle later out_state=0x00050a0f04090e03080d02070c01060b, out_tag=3, out_inv=0.
- NB=4, same input, inv=1 -> out_state=0x000d0a0704010e0b0805020f0c090603.
- NB=8, PIPE_STAGES=3: 100 random blocks forward, outputs fed back with inv=1 -> every block equals its original. Check row 2 uses offset 3 and row 3 uses offset 4 against the reference model.
- NB=6, PIPE_STAGES=2, in_valid always 1, out_ready toggling 1,0,0,1,…:
  - no loss or duplication
  - outputs stay stable while stalled
  - in-order tag sequence 0..15
  - in_ready=0 only when both stages are full and out_ready=0
- Reset asserted with 2 blocks in flight -> out_valid drops to 0 asynchronously. After release, the first new block emerges after exactly PIPE_STAGES cycles.
- With SHIFT_ROWS_PIPE_STATS_EN: 10 handshakes and 4 stall cycles -> blk_count=10, stall_cycles=4. Preload blk_count near wrap -> rolls to 0.
